// File: rtl/demux2to1bus_reg_if.sv
// Bus bundle for demux2to1bus_reg: one input stream, two output channels and
// the per-channel delivery counters. dbg_state carries the channel states as {b, a}.
interface demux2to1bus_reg_if #(
   parameter int DATA_W = 32,
   parameter int CNT_W  = 16
);
   // Every stream uses the same valid/ready rule. A word moves on a rising edge
   // when valid && ready. The sender holds valid and data stable until that edge.
   // in_ready may depend on in_sel and on the target channel, never on in_valid.
   logic              in_valid;
   logic              in_ready;
   logic              in_sel;
   logic [DATA_W-1:0] in_data;
   logic              a_valid;
   logic              a_ready;
   logic [DATA_W-1:0] a_data;
   logic              b_valid;
   logic              b_ready;
   logic [DATA_W-1:0] b_data;
   logic [CNT_W-1:0]  a_count;
   logic [CNT_W-1:0]  b_count;
   logic [1:0]        dbg_state;

   modport master (
      output in_valid, in_sel, in_data, a_ready, b_ready,
      input  in_ready, a_valid, a_data, b_valid, b_data, a_count, b_count, dbg_state
   );

   modport slave (
      input  in_valid, in_sel, in_data, a_ready, b_ready,
      output in_ready, a_valid, a_data, b_valid, b_data, a_count, b_count, dbg_state
   );
endinterface

// File: rtl/demux2to1bus_reg.sv
// Registered 1-to-2 bus demultiplexer with one holding register per channel.
// Optional macro DEMUX2TO1BUS_CNT_EN enables the per-channel delivery counters.
module demux2to1bus_reg #(
   parameter int DATA_W = 32,
   parameter int CNT_W  = 16
) (
   input logic               clk,
   input logic               reset,
   demux2to1bus_reg_if.slave bus
);
   typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} chan_state_e;

   chan_state_e       a_state_q, a_state_d;
   chan_state_e       b_state_q, b_state_d;
   logic [DATA_W-1:0] a_data_q, a_data_d;
   logic [DATA_W-1:0] b_data_q, b_data_d;
   logic              in_ready;
   logic              a_drain, b_drain;
   logic              a_load, b_load;

   // A channel can take a word if it is empty or is being drained on this edge.
   always_comb begin
      a_drain  = (a_state_q == FULL) && bus.a_ready;
      b_drain  = (b_state_q == FULL) && bus.b_ready;
      in_ready = bus.in_sel ? ((b_state_q == EMPTY) || bus.b_ready)
                            : ((a_state_q == EMPTY) || bus.a_ready);
      a_load   = bus.in_valid && in_ready && !bus.in_sel;
      b_load   = bus.in_valid && in_ready &&  bus.in_sel;
   end

   always_comb begin
      a_state_d = a_state_q;
      b_state_d = b_state_q;
      a_data_d  = a_data_q;
      b_data_d  = b_data_q;
      if (a_load) begin
         a_state_d = FULL;
         a_data_d  = bus.in_data;
      end else if (a_drain) begin
         a_state_d = EMPTY;
      end
      if (b_load) begin
         b_state_d = FULL;
         b_data_d  = bus.in_data;
      end else if (b_drain) begin
         b_state_d = EMPTY;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         a_state_q <= EMPTY;
         b_state_q <= EMPTY;
         a_data_q  <= '0;
         b_data_q  <= '0;
      end else begin
         a_state_q <= a_state_d;
         b_state_q <= b_state_d;
         a_data_q  <= a_data_d;
         b_data_q  <= b_data_d;
      end
   end

   assign bus.in_ready  = in_ready;
   assign bus.a_valid   = (a_state_q == FULL);
   assign bus.b_valid   = (b_state_q == FULL);
   assign bus.a_data    = a_data_q;
   assign bus.b_data    = b_data_q;
   assign bus.dbg_state = {b_state_q, a_state_q};

`ifdef DEMUX2TO1BUS_CNT_EN
   logic [CNT_W-1:0] a_count_q, a_count_d;
   logic [CNT_W-1:0] b_count_q, b_count_d;

   // The counters wrap naturally at the width of the register.
   always_comb begin
      a_count_d = a_count_q;
      b_count_d = b_count_q;
      if (a_drain) a_count_d = a_count_q + 1'b1;
      if (b_drain) b_count_d = b_count_q + 1'b1;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         a_count_q <= '0;
         b_count_q <= '0;
      end else begin
         a_count_q <= a_count_d;
         b_count_q <= b_count_d;
      end
   end

   assign bus.a_count = a_count_q;
   assign bus.b_count = b_count_q;
`else
   assign bus.a_count = {CNT_W{1'b0}};
   assign bus.b_count = {CNT_W{1'b0}};
`endif
endmodule

// File: tb/tb_demux2to1bus_reg.sv
// Self-checking bench for demux2to1bus_reg: scenario tasks plus a per-channel
// expected-word queue that is updated on every accept and every drain.
module tb_demux2to1bus_reg;
   localparam int DATA_W = 32;
   localparam int CNT_W  = 4;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   demux2to1bus_reg_if #(.DATA_W(DATA_W), .CNT_W(CNT_W)) bus ();

   demux2to1bus_reg #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   logic [DATA_W-1:0] exp_a_q[$];
   logic [DATA_W-1:0] exp_b_q[$];
   logic [CNT_W-1:0]  exp_a_cnt;
   logic [CNT_W-1:0]  exp_b_cnt;
   int n_checks     = 0;
   int n_fail       = 0;
   int tot_a_drains = 0;
   int tot_b_drains = 0;

   task automatic idle();
      bus.in_valid = 1'b0;
      bus.in_sel   = 1'b0;
      bus.in_data  = '0;
      bus.a_ready  = 1'b0;
      bus.b_ready  = 1'b0;
   endtask

   // Scoreboard update at the falling edge, then advance to just after the next rising edge.
   task automatic tick();
      logic [DATA_W-1:0] head;
      @(negedge clk);
      if (reset) begin
         exp_a_q.delete();
         exp_b_q.delete();
         exp_a_cnt = '0;
         exp_b_cnt = '0;
      end else begin
         n_checks++;
         if (bus.a_valid === 1'b1) begin
            head = (exp_a_q.size() != 0) ? exp_a_q[0] : 'x;
            if (exp_a_q.size() == 0 || bus.a_data !== head) begin
               n_fail++;
               $display("FAIL sb_a: a_data=%h expected %h (queued %0d)", bus.a_data, head, exp_a_q.size());
            end
            if (bus.a_ready) begin
               if (exp_a_q.size() != 0) void'(exp_a_q.pop_front());
               tot_a_drains++;
               exp_a_cnt++;
            end
         end else if (exp_a_q.size() != 0) begin
            n_fail++;
            $display("FAIL sb_a_valid: a_valid=%b expected 1 (queued %0d)", bus.a_valid, exp_a_q.size());
         end
         n_checks++;
         if (bus.b_valid === 1'b1) begin
            head = (exp_b_q.size() != 0) ? exp_b_q[0] : 'x;
            if (exp_b_q.size() == 0 || bus.b_data !== head) begin
               n_fail++;
               $display("FAIL sb_b: b_data=%h expected %h (queued %0d)", bus.b_data, head, exp_b_q.size());
            end
            if (bus.b_ready) begin
               if (exp_b_q.size() != 0) void'(exp_b_q.pop_front());
               tot_b_drains++;
               exp_b_cnt++;
            end
         end else if (exp_b_q.size() != 0) begin
            n_fail++;
            $display("FAIL sb_b_valid: b_valid=%b expected 1 (queued %0d)", bus.b_valid, exp_b_q.size());
         end
         if (bus.in_valid && bus.in_ready === 1'b1) begin
            if (bus.in_sel) exp_b_q.push_back(bus.in_data);
            else            exp_a_q.push_back(bus.in_data);
         end
      end
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      idle();
      bus.in_valid = 1'b1;
      bus.in_sel   = 1'b1;
      bus.in_data  = 32'hFFFF_FFFF;
      tick();
      tick();
      reset = 1'b0;
      idle();
      n_checks++;
      if ({bus.a_valid, bus.b_valid} !== 2'b00) begin
         n_fail++; $display("FAIL reset_valid: got %b expected 00", {bus.a_valid, bus.b_valid});
      end
      n_checks++;
      if (bus.a_data !== '0 || bus.b_data !== '0) begin
         n_fail++; $display("FAIL reset_data: a=%h b=%h expected 0", bus.a_data, bus.b_data);
      end
      n_checks++;
      if (bus.a_count !== '0 || bus.b_count !== '0) begin
         n_fail++; $display("FAIL reset_count: a=%0d b=%0d expected 0", bus.a_count, bus.b_count);
      end
      // Mid-stream reset with A stalled and a B word offered during reset.
      bus.in_valid = 1'b1;
      bus.in_data  = 32'h1234;
      tick();
      idle();
      n_checks++;
      if (bus.a_valid !== 1'b1 || bus.a_data !== 32'h1234) begin
         n_fail++; $display("FAIL reset_preload: a_valid=%b a_data=%h expected 1/1234", bus.a_valid, bus.a_data);
      end
      reset = 1'b1;
      bus.in_valid = 1'b1;
      bus.in_sel   = 1'b1;
      bus.in_data  = 32'hBBBB;
      tick();
      reset = 1'b0;
      idle();
      n_checks++;
      if (bus.a_valid !== 1'b0 || bus.a_data !== '0 || bus.b_valid !== 1'b0 || bus.a_count !== '0) begin
         n_fail++;
         $display("FAIL reset_mid: a_valid=%b a_data=%h b_valid=%b a_count=%0d expected 0/0/0/0",
                  bus.a_valid, bus.a_data, bus.b_valid, bus.a_count);
      end
   endtask

   task automatic test_route();
      bus.a_ready  = 1'b1;
      bus.in_valid = 1'b1;
      bus.in_sel   = 1'b0;
      bus.in_data  = 32'hDEAD_BEEF;
      #1;
      n_checks++;
      if (bus.in_ready !== 1'b1) begin
         n_fail++; $display("FAIL route_a_ready: in_ready=%b expected 1", bus.in_ready);
      end
      tick();
      bus.in_valid = 1'b0;
      n_checks++;
      if (bus.a_valid !== 1'b1 || bus.a_data !== 32'hDEAD_BEEF || bus.b_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL route_a: a_valid=%b a_data=%h b_valid=%b expected 1/deadbeef/0", bus.a_valid, bus.a_data, bus.b_valid);
      end
      tick();
      n_checks++;
      if (bus.a_valid !== 1'b0 || bus.a_data !== 32'hDEAD_BEEF) begin
         n_fail++; $display("FAIL route_a_after_drain: a_valid=%b a_data=%h expected 0/deadbeef", bus.a_valid, bus.a_data);
      end
      idle();
      bus.in_valid = 1'b1;
      bus.in_sel   = 1'b1;
      bus.in_data  = 32'hCAFE_F00D;
      tick();
      bus.in_valid = 1'b0;
      n_checks++;
      if (bus.b_valid !== 1'b1 || bus.b_data !== 32'hCAFE_F00D || bus.a_valid !== 1'b0 || bus.a_data !== 32'hDEAD_BEEF) begin
         n_fail++;
         $display("FAIL route_b: b_valid=%b b_data=%h a_valid=%b a_data=%h expected 1/cafef00d/0/deadbeef",
                  bus.b_valid, bus.b_data, bus.a_valid, bus.a_data);
      end
      bus.b_ready = 1'b1;
      tick();
      idle();
   endtask

   task automatic test_backpressure();
      idle();
      bus.in_valid = 1'b1;
      bus.in_data  = 32'h11;
      tick();
      bus.in_data = 32'h99;
      #1;
      n_checks++;
      if (bus.in_ready !== 1'b0) begin
         n_fail++; $display("FAIL bp_in_ready_a: in_ready=%b expected 0", bus.in_ready);
      end
      tick();
      n_checks++;
      if (bus.a_valid !== 1'b1 || bus.a_data !== 32'h11) begin
         n_fail++; $display("FAIL bp_hold_a: a_valid=%b a_data=%h expected 1/11", bus.a_valid, bus.a_data);
      end
      bus.in_sel  = 1'b1;
      bus.in_data = 32'h22;
      #1;
      n_checks++;
      if (bus.in_ready !== 1'b1) begin
         n_fail++; $display("FAIL bp_in_ready_b: in_ready=%b expected 1", bus.in_ready);
      end
      tick();
      bus.in_valid = 1'b0;
      n_checks++;
      if (bus.b_valid !== 1'b1 || bus.b_data !== 32'h22 || bus.a_data !== 32'h11) begin
         n_fail++;
         $display("FAIL bp_cross: b_valid=%b b_data=%h a_data=%h expected 1/22/11", bus.b_valid, bus.b_data, bus.a_data);
      end
      bus.a_ready = 1'b1;
      bus.b_ready = 1'b1;
      tick();
      n_checks++;
      if ({bus.a_valid, bus.b_valid} !== 2'b00) begin
         n_fail++; $display("FAIL bp_dual_drain: valids=%b expected 00", {bus.a_valid, bus.b_valid});
      end
      idle();
   endtask

   task automatic test_back_to_back();
      bus.a_ready = 1'b1;
      for (int i = 0; i < 8; i++) begin
         bus.in_valid = 1'b1;
         bus.in_sel   = 1'b0;
         bus.in_data  = 32'(i);
         #1;
         n_checks++;
         if (bus.in_ready !== 1'b1) begin
            n_fail++; $display("FAIL b2b_ready[%0d]: in_ready=%b expected 1", i, bus.in_ready);
         end
         tick();
         n_checks++;
         if (bus.a_valid !== 1'b1 || bus.a_data !== 32'(i)) begin
            n_fail++; $display("FAIL b2b_data[%0d]: a_valid=%b a_data=%h expected 1/%h", i, bus.a_valid, bus.a_data, 32'(i));
         end
      end
      bus.in_valid = 1'b0;
      tick();
      idle();
   endtask

   task automatic test_drain_load();
      int drains_before;
      idle();
      bus.in_valid = 1'b1;
      bus.in_data  = 32'h5;
      tick();
      drains_before = tot_a_drains;
      bus.a_ready = 1'b1;
      bus.in_data = 32'h6;
      tick();
      idle();
      n_checks++;
      if (bus.a_valid !== 1'b1 || bus.a_data !== 32'h6) begin
         n_fail++; $display("FAIL drain_load: a_valid=%b a_data=%h expected 1/6", bus.a_valid, bus.a_data);
      end
      tick();
      n_checks++;
      if (tot_a_drains - drains_before != 1) begin
         n_fail++; $display("FAIL drain_load_once: drains=%0d expected 1", tot_a_drains - drains_before);
      end
      bus.a_ready = 1'b1;
      tick();
      idle();
   endtask

   task automatic test_counter();
      logic [CNT_W-1:0] want_a, want_b, fix_a, fix_b;
      reset = 1'b1;
      idle();
      tick();
      reset = 1'b0;
      bus.a_ready = 1'b1;
      bus.b_ready = 1'b1;
      for (int i = 0; i < 20; i++) begin
         bus.in_valid = 1'b1;
         bus.in_sel   = (i >= 17);
         bus.in_data  = 32'h100 + 32'(i);
         tick();
      end
      bus.in_valid = 1'b0;
      tick();
`ifdef DEMUX2TO1BUS_CNT_EN
      want_a = exp_a_cnt;
      want_b = exp_b_cnt;
      fix_a  = 4'd1;
      fix_b  = 4'd3;
`else
      want_a = '0;
      want_b = '0;
      fix_a  = '0;
      fix_b  = '0;
`endif
      n_checks++;
      if (bus.a_count !== want_a || bus.b_count !== want_b) begin
         n_fail++; $display("FAIL count_model: a=%0d b=%0d expected %0d/%0d", bus.a_count, bus.b_count, want_a, want_b);
      end
      n_checks++;
      if (bus.a_count !== fix_a || bus.b_count !== fix_b) begin
         n_fail++; $display("FAIL count_wrap: a=%0d b=%0d expected %0d/%0d", bus.a_count, bus.b_count, fix_a, fix_b);
      end
      idle();
   endtask

   task automatic test_random();
      for (int i = 0; i < 400; i++) begin
         bus.in_valid = 1'($urandom_range(0, 1));
         bus.in_sel   = 1'($urandom_range(0, 1));
         bus.in_data  = $urandom();
         bus.a_ready  = ($urandom_range(0, 3) != 0);
         bus.b_ready  = ($urandom_range(0, 3) == 0);
         tick();
      end
      idle();
      bus.a_ready = 1'b1;
      bus.b_ready = 1'b1;
      tick();
      tick();
      n_checks++;
      if (exp_a_q.size() != 0 || exp_b_q.size() != 0 || bus.a_valid !== 1'b0 || bus.b_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL random_flush: queued a=%0d b=%0d valids=%b expected 0/0/00",
                  exp_a_q.size(), exp_b_q.size(), {bus.a_valid, bus.b_valid});
      end
      idle();
   endtask

   initial begin
      reset     = 1'b1;
      exp_a_cnt = '0;
      exp_b_cnt = '0;
      idle();
      @(posedge clk);
      #1;
      test_reset();
      test_route();
      test_backpressure();
      test_back_to_back();
      test_drain_load();
      test_counter();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
